yk_avg_compute: RTL and testbench
=================================

// Module: yk_avg_compute
// PURPOSE
//  Multi-channel servo feedback conditioner. On each compute strobe it snapshots CH
//  unsigned pot readings and updates a per-channel 2^LOG2_AVG-deep moving average.
//  It then removes the mid-scale OFFSET and outputs signed, saturated yk words.
//  Sits between the pot/ADC capture and the per-axis control-law blocks.
//
// PARAMETERS
//  CH        2    number of servo channels
//  IN_W      8    width of each unsigned pot sample
//  OUT_W     9    width of each signed yk output (two's complement)
//  OFFSET    128  mid-scale value subtracted from the average (0..2^IN_W-1)
//  LOG2_AVG  2    log2 of the moving-average depth (0 = no averaging)
//
// PORTS
//  clk       in   1          system clock, all logic on posedge
//  rst       in   1          synchronous, active-high reset
//  compute   in   1          start a conversion pass; honoured only when busy=0
//  pot       in   CH*IN_W    channel c at [c*IN_W +: IN_W], unsigned
//  yk        out  CH*OUT_W   channel c at [c*OUT_W +: OUT_W], signed, registered
//  yk_sat    out  CH         1 = channel result was clipped on the last pass
//  yk_valid  out  1          1-cycle pulse: yk and yk_sat just updated
//  busy      out  1          high from the cycle after compute is accepted until DONE ends
//
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge):
//   - yk=0, yk_sat=0, yk_valid=0, busy=0, state=IDLE
//   - all history entries and sums cleared; primed=0
//   - reset mid-pass aborts the pass: no yk_valid and no partial yk update
//  FSM: IDLE -> SAMPLE (CH cycles, ch_idx 0..CH-1) -> DONE (1 cycle) -> IDLE
//   - IDLE: compute=1 latches all of pot into snap_q, ch_idx=0, goes to SAMPLE
//   - compute during SAMPLE or DONE is ignored (not queued)
//   - SAMPLE, channel ch_idx:
//       primed=0: fill every history slot with the sample; sum = sample << LOG2_AVG
//       primed=1: sum = sum + new - ring[wptr]; ring[wptr] = new
//       result goes to a staging register, not to yk
//   - wptr is shared by all channels; it advances modulo 2^LOG2_AVG after ch CH-1
//   - leaving the last SAMPLE cycle: yk and yk_sat load from staging together; primed=1
//   - DONE: yk_valid=1 for exactly this cycle
//   - latency: compute accepted at edge N -> yk_valid high in cycle N+CH+1
//  Arithmetic:
//   - sum is unsigned, IN_W+LOG2_AVG bits wide and never overflows
//   - avg = sum >> LOG2_AVG, truncating
//   - diff = avg - OFFSET, signed, IN_W+1 bits
//   - OUT_W >= IN_W+1: diff is sign-extended, sat=0
//   - otherwise clip to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set sat=1 on clip
//  Hold: yk and yk_sat hold between passes; yk_valid=0 and busy=0 outside a pass.
//
// STRUCTURE
//  Shared package yk_pkg:
//   - state enum {IDLE, SAMPLE, DONE}
//   - function sat_signed(value, out_w)
//   - default localparams for IN_W, OUT_W and OFFSET
//  One sub-module, yk_avg_channel, generated CH times. Each instance holds:
//   - the history ring and running sum
//   - inputs: clk, rst, en, prime, wptr, sample; output: avg
//  Top level holds:
//   - sequencer FSM, ch_idx, wptr, snapshot
//   - offset/saturate datapath, staging and output registers
//
// TESTING  (defaults unless stated)
//  1 rst held 3 cycles, then released with compute=0
//    -> yk=0, yk_sat=0, yk_valid=0, busy=0
//  2 first compute, pot ch0=128, ch1=200
//    -> yk_valid 3 cycles later; yk ch0=0, ch1=+72; busy high 3 cycles
//  3 ch0 primed at 128, next passes 132, 136, 140, 144
//    -> yk ch0 = 1, 3, 6, 10 (ring wrap drops the 128)
//  4 pot=0 -> yk=-128 (9'h180); pot=255 -> +127, sat=0
//    -> with OUT_W=7, pot=255 gives +63, yk_sat=1
//  5 compute re-asserted during SAMPLE and DONE -> ignored, exactly one yk_valid
//    -> with CH=4, LOG2_AVG=0: yk equals pot-OFFSET per channel, latency 5
//  6 rst asserted in the 2nd SAMPLE cycle -> no yk_valid, yk=0
//    -> the next compute re-primes: pot 100 gives yk=-28

Source files
------------

// File: rtl/yk_pkg.sv
// Shared types and helpers for the yk servo feedback conditioner.
// The sequencer states, the default widths and the signed clip helper are shared here.
package yk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int DEF_IN_W   = 8;
  localparam int DEF_OUT_W  = 9;
  localparam int DEF_OFFSET = 128;

  // Clamp a signed value into the range of an out_w-bit two's complement word.
  function automatic int sat_signed(input int value, input int out_w);
    int hi;
    int lo;
    hi = (1 << (out_w - 1)) - 1;
    lo = -(1 << (out_w - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/yk_avg_channel.sv
// One channel of the moving average: history ring plus running sum.
// avg is the average the running sum will hold once the current sample is absorbed.
module yk_avg_channel
  import yk_pkg::*;
#(
  parameter int IN_W     = DEF_IN_W,
  parameter int LOG2_AVG = 2,
  parameter int PW       = (LOG2_AVG > 0) ? LOG2_AVG : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            prime,
  input  logic [PW-1:0]   wptr,
  input  logic [IN_W-1:0] sample,
  output logic [IN_W-1:0] avg
);

  localparam int DEPTH = 1 << LOG2_AVG;
  localparam int SW    = IN_W + LOG2_AVG;

  logic [IN_W-1:0] ring [DEPTH];
  logic [SW-1:0]   sum_q;
  logic [SW-1:0]   sum_next;

  // The add/subtract may wrap transiently, but the true sum always fits in SW bits.
  always_comb begin
    sum_next = sum_q;
    if (prime) begin
      sum_next = SW'(sample) << LOG2_AVG;
    end else begin
      sum_next = sum_q + SW'(sample) - SW'(ring[wptr]);
    end
  end

  assign avg = IN_W'(sum_next >> LOG2_AVG);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ring[i] <= '0;
      end
    end else if (en) begin
      sum_q <= sum_next;
      if (prime) begin
        for (int i = 0; i < DEPTH; i++) begin
          ring[i] <= sample;
        end
      end else begin
        ring[wptr] <= sample;
      end
    end
  end

endmodule

// File: rtl/yk_avg_compute.sv
// Multi-channel servo feedback conditioner: snapshot, moving average, offset removal
// and signed saturation, sequenced one channel per cycle.
module yk_avg_compute
  import yk_pkg::*;
#(
  parameter int CH       = 2,
  parameter int IN_W     = DEF_IN_W,
  parameter int OUT_W    = DEF_OUT_W,
  parameter int OFFSET   = DEF_OFFSET,
  parameter int LOG2_AVG = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                compute,
  input  logic [CH*IN_W-1:0]  pot,
  output logic [CH*OUT_W-1:0] yk,
  output logic [CH-1:0]       yk_sat,
  output logic                yk_valid,
  output logic                busy
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = (LOG2_AVG > 0) ? LOG2_AVG : 1;

  state_t                state;
  logic [CW-1:0]         ch_idx;
  logic [PW-1:0]         wptr;
  logic                  primed;
  logic [IN_W-1:0]       snap_q [CH];
  logic [IN_W-1:0]       avg    [CH];
  logic [CH*OUT_W-1:0]   stage_q;
  logic [CH*OUT_W-1:0]   stage_next;
  logic [CH-1:0]         stsat_q;
  logic [CH-1:0]         stsat_next;
  logic [IN_W-1:0]       cur_avg;
  logic signed [IN_W:0]  diff;
  int                    clipped;
  logic [OUT_W-1:0]      res;
  logic                  res_sat;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    yk_avg_channel #(
      .IN_W    (IN_W),
      .LOG2_AVG(LOG2_AVG)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en    (state == SAMPLE && ch_idx == CW'(c)),
      .prime (!primed),
      .wptr  (wptr),
      .sample(snap_q[c]),
      .avg   (avg[c])
    );
  end

  assign cur_avg = avg[ch_idx];
  assign diff    = $signed({1'b0, cur_avg}) - $signed((IN_W + 1)'(OFFSET));
  assign clipped = sat_signed(int'(diff), OUT_W);
  assign res     = clipped[OUT_W-1:0];
  assign res_sat = (clipped != int'(diff));

  // Staging with the active channel's fresh result merged in, so the last
  // channel can reach yk on the same edge it is computed.
  always_comb begin
    stage_next = stage_q;
    stsat_next = stsat_q;
    stage_next[ch_idx*OUT_W +: OUT_W] = res;
    stsat_next[ch_idx] = res_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ch_idx   <= '0;
      wptr     <= '0;
      primed   <= 1'b0;
      busy     <= 1'b0;
      yk_valid <= 1'b0;
      yk       <= '0;
      yk_sat   <= '0;
      stage_q  <= '0;
      stsat_q  <= '0;
      for (int i = 0; i < CH; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      yk_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (compute) begin
            for (int i = 0; i < CH; i++) begin
              snap_q[i] <= pot[i*IN_W +: IN_W];
            end
            ch_idx <= '0;
            busy   <= 1'b1;
            state  <= SAMPLE;
          end
        end
        SAMPLE: begin
          stage_q <= stage_next;
          stsat_q <= stsat_next;
          if (ch_idx == CW'(CH - 1)) begin
            yk       <= stage_next;
            yk_sat   <= stsat_next;
            primed   <= 1'b1;
            wptr     <= (LOG2_AVG == 0) ? '0 : wptr + 1'b1;
            yk_valid <= 1'b1;
            state    <= DONE;
          end else begin
            ch_idx <= ch_idx + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yk_avg_compute.sv
// Self-checking bench for yk_avg_compute: three configurations checked against a
// sliding-window average model of the conditioner.
module tb_yk_avg_compute;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        compute_a, compute_b, compute_c;
  logic [15:0] pot_a, pot_b;
  logic [31:0] pot_c;
  logic [17:0] yk_a;
  logic [13:0] yk_b;
  logic [35:0] yk_c;
  logic [1:0]  sat_a, sat_b;
  logic [3:0]  sat_c;
  logic        valid_a, valid_b, valid_c;
  logic        busy_a, busy_b, busy_c;

  int errors = 0;
  int checks = 0;

  yk_avg_compute dut_a (
    .clk(clk), .rst(rst), .compute(compute_a), .pot(pot_a),
    .yk(yk_a), .yk_sat(sat_a), .yk_valid(valid_a), .busy(busy_a)
  );

  yk_avg_compute #(.OUT_W(7)) dut_b (
    .clk(clk), .rst(rst), .compute(compute_b), .pot(pot_b),
    .yk(yk_b), .yk_sat(sat_b), .yk_valid(valid_b), .busy(busy_b)
  );

  yk_avg_compute #(.CH(4), .LOG2_AVG(0)) dut_c (
    .clk(clk), .rst(rst), .compute(compute_c), .pot(pot_c),
    .yk(yk_c), .yk_sat(sat_c), .yk_valid(valid_c), .busy(busy_c)
  );

  // Reference model: last-N sample windows per instance/channel
  int hist [12][$];
  bit primed [3];
  int exp_y [4];
  bit exp_s [4];

  function automatic int nch(input int inst);
    return (inst == 2) ? 4 : 2;
  endfunction

  function automatic int depth(input int inst);
    return (inst == 2) ? 1 : 4;
  endfunction

  function automatic int outw(input int inst);
    return (inst == 1) ? 7 : 9;
  endfunction

  function automatic logic signed [31:0] act_yk(input int inst, input int c);
    case (inst)
      0:       return $signed(yk_a[c*9 +: 9]);
      1:       return $signed(yk_b[c*7 +: 7]);
      default: return $signed(yk_c[c*9 +: 9]);
    endcase
  endfunction

  function automatic logic act_sat(input int inst, input int c);
    case (inst)
      0:       return sat_a[c];
      1:       return sat_b[c];
      default: return sat_c[c];
    endcase
  endfunction

  function automatic logic act_valid(input int inst);
    case (inst)
      0:       return valid_a;
      1:       return valid_b;
      default: return valid_c;
    endcase
  endfunction

  function automatic logic act_busy(input int inst);
    case (inst)
      0:       return busy_a;
      1:       return busy_b;
      default: return busy_c;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 12; k++) hist[k].delete();
    for (int i = 0; i < 3; i++) primed[i] = 1'b0;
  endtask

  task automatic model_pass(input int inst, input int p0, input int p1, input int p2, input int p3);
    int p [4];
    int k, sum, avgv, d, hi, lo;
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    hi = (1 << (outw(inst) - 1)) - 1;
    lo = -(1 << (outw(inst) - 1));
    for (int c = 0; c < nch(inst); c++) begin
      k = inst * 4 + c;
      if (!primed[inst]) begin
        hist[k].delete();
        for (int i = 0; i < depth(inst); i++) hist[k].push_back(p[c]);
      end else begin
        hist[k].push_back(p[c]);
        void'(hist[k].pop_front());
      end
      sum = 0;
      foreach (hist[k][i]) sum += hist[k][i];
      avgv = sum / depth(inst);
      d = avgv - 128;
      if (d > hi) begin
        exp_y[c] = hi; exp_s[c] = 1'b1;
      end else if (d < lo) begin
        exp_y[c] = lo; exp_s[c] = 1'b1;
      end else begin
        exp_y[c] = d; exp_s[c] = 1'b0;
      end
    end
    primed[inst] = 1'b1;
  endtask

  task automatic set_compute(input int inst, input logic v);
    case (inst)
      0:       compute_a = v;
      1:       compute_b = v;
      default: compute_c = v;
    endcase
  endtask

  // One full pass; compute stays high for 'hold' cycles after acceptance
  task automatic applyStimulus(input int inst, input int p0, input int p1, input int p2,
                               input int p3, input int hold,
                               output int lat, output int busy_cnt, output int valid_cnt);
    @(negedge clk);
    case (inst)
      0:       pot_a = {p1[7:0], p0[7:0]};
      1:       pot_b = {p1[7:0], p0[7:0]};
      default: pot_c = {p3[7:0], p2[7:0], p1[7:0], p0[7:0]};
    endcase
    set_compute(inst, 1'b1);
    @(posedge clk);
    lat = -1; busy_cnt = 0; valid_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (act_busy(inst) === 1'b1) busy_cnt++;
      if (act_valid(inst) === 1'b1) begin
        valid_cnt++;
        if (lat < 0) lat = k;
      end
      if (k > hold) set_compute(inst, 1'b0);
    end
    model_pass(inst, p0, p1, p2, p3);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    compute_a = 0; compute_b = 0; compute_c = 0;
    pot_a = '0; pot_b = '0; pot_c = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({yk_a, yk_b, yk_c} !== '0) begin
      errors++; $display("[TB] FAIL reset_yk got %h/%h/%h want 0", yk_a, yk_b, yk_c);
    end
    checks++; if ({sat_a, sat_b, sat_c} !== '0) begin
      errors++; $display("[TB] FAIL reset_sat got %b/%b/%b want 0", sat_a, sat_b, sat_c);
    end
    checks++; if ({valid_a, valid_b, valid_c} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_valid got %b%b%b want 000", valid_a, valid_b, valid_c);
    end
    checks++; if ({busy_a, busy_b, busy_c} !== 3'b000) begin
      errors++; $display("[TB] FAIL reset_busy got %b%b%b want 000", busy_a, busy_b, busy_c);
    end
  endtask

  task automatic test_first_pass();
    int lat, bc, vc;
    applyStimulus(0, 128, 200, 0, 0, 0, lat, bc, vc);
    checks++; if (lat != 3) begin
      errors++; $display("[TB] FAIL first_latency got %0d want 3", lat);
    end
    checks++; if (bc != 3) begin
      errors++; $display("[TB] FAIL first_busy_cycles got %0d want 3", bc);
    end
    checks++; if (vc != 1) begin
      errors++; $display("[TB] FAIL first_valid_count got %0d want 1", vc);
    end
    checks++; if (act_yk(0, 0) !== 0) begin
      errors++; $display("[TB] FAIL first_yk0 got %0d want 0", act_yk(0, 0));
    end
    checks++; if (act_yk(0, 1) !== 72) begin
      errors++; $display("[TB] FAIL first_yk1 got %0d want 72", act_yk(0, 1));
    end
    checks++; if (sat_a !== 2'b00) begin
      errors++; $display("[TB] FAIL first_sat got %b want 00", sat_a);
    end
  endtask

  task automatic test_moving_avg();
    int lat, bc, vc;
    int want [4];
    want[0] = 1; want[1] = 3; want[2] = 6; want[3] = 10;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 132 + 4 * i, $urandom_range(0, 255), 0, 0, 0, lat, bc, vc);
      checks++; if (act_yk(0, 0) !== want[i]) begin
        errors++; $display("[TB] FAIL mavg_yk0[%0d] got %0d want %0d", i, act_yk(0, 0), want[i]);
      end
      checks++; if (act_yk(0, 1) !== exp_y[1]) begin
        errors++; $display("[TB] FAIL mavg_yk1[%0d] got %0d want %0d", i, act_yk(0, 1), exp_y[1]);
      end
    end
  endtask

  task automatic test_extremes();
    int lat, bc, vc;
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0, lat, bc, vc);
    checks++; if (yk_a !== {2{9'h180}}) begin
      errors++; $display("[TB] FAIL ext_min_yk got %h want %h", yk_a, {2{9'h180}});
    end
    checks++; if (sat_a !== 2'b00) begin
      errors++; $display("[TB] FAIL ext_min_sat got %b want 00", sat_a);
    end
    repeat (4) applyStimulus(0, 255, 255, 0, 0, 0, lat, bc, vc);
    checks++; if (act_yk(0, 0) !== 127 || act_yk(0, 1) !== 127) begin
      errors++; $display("[TB] FAIL ext_max_yk got %0d,%0d want 127", act_yk(0, 0), act_yk(0, 1));
    end
    checks++; if (sat_a !== 2'b00) begin
      errors++; $display("[TB] FAIL ext_max_sat got %b want 00", sat_a);
    end
    applyStimulus(1, 255, 0, 0, 0, 0, lat, bc, vc);
    checks++; if (act_yk(1, 0) !== 63 || act_yk(1, 1) !== -64) begin
      errors++; $display("[TB] FAIL narrow_clip_yk got %0d,%0d want 63,-64", act_yk(1, 0), act_yk(1, 1));
    end
    checks++; if (sat_b !== 2'b11) begin
      errors++; $display("[TB] FAIL narrow_clip_sat got %b want 11", sat_b);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 140, 128, 0, 0, 0, lat, bc, vc);
      for (int c = 0; c < 2; c++) begin
        checks++; if (act_yk(1, c) !== exp_y[c] || act_sat(1, c) !== exp_s[c]) begin
          errors++; $display("[TB] FAIL narrow_pass[%0d] ch%0d got %0d/%b want %0d/%b",
                             i, c, act_yk(1, c), act_sat(1, c), exp_y[c], exp_s[c]);
        end
      end
    end
    checks++; if (act_yk(1, 0) !== 12 || sat_b !== 2'b00) begin
      errors++; $display("[TB] FAIL narrow_settle got %0d/%b want 12/00", act_yk(1, 0), sat_b);
    end
  endtask

  task automatic test_ignore_compute();
    int lat, bc, vc;
    applyStimulus(0, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 3, lat, bc, vc);
    checks++; if (vc != 1 || lat != 3 || bc != 3) begin
      errors++; $display("[TB] FAIL ignore_a valid=%0d lat=%0d busy=%0d want 1/3/3", vc, lat, bc);
    end
    for (int c = 0; c < 2; c++) begin
      checks++; if (act_yk(0, c) !== exp_y[c]) begin
        errors++; $display("[TB] FAIL ignore_a_yk ch%0d got %0d want %0d", c, act_yk(0, c), exp_y[c]);
      end
    end
  endtask

  task automatic test_wide();
    int lat, bc, vc;
    int p [4];
    for (int i = 0; i < 4; i++) p[i] = $urandom_range(0, 255);
    applyStimulus(2, p[0], p[1], p[2], p[3], 0, lat, bc, vc);
    checks++; if (lat != 5 || bc != 5 || vc != 1) begin
      errors++; $display("[TB] FAIL wide_timing lat=%0d busy=%0d valid=%0d want 5/5/1", lat, bc, vc);
    end
    for (int c = 0; c < 4; c++) begin
      checks++; if (act_yk(2, c) !== p[c] - 128 || act_sat(2, c) !== 1'b0) begin
        errors++; $display("[TB] FAIL wide_yk ch%0d got %0d/%b want %0d/0", c, act_yk(2, c), act_sat(2, c), p[c] - 128);
      end
    end
    applyStimulus(2, 10, 20, 30, 40, 5, lat, bc, vc);
    checks++; if (vc != 1 || lat != 5) begin
      errors++; $display("[TB] FAIL wide_ignore valid=%0d lat=%0d want 1/5", vc, lat);
    end
    checks++; if (act_yk(2, 3) !== -88) begin
      errors++; $display("[TB] FAIL wide_ignore_yk got %0d want -88", act_yk(2, 3));
    end
  endtask

  task automatic test_reset_mid_pass();
    int lat, bc, vc;
    int seen;
    seen = 0;
    @(negedge clk);
    pot_a = {8'd77, 8'd99};
    compute_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    compute_a = 1'b0;
    if (valid_a === 1'b1) seen++;
    @(negedge clk);
    if (valid_a === 1'b1) seen++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      if (valid_a === 1'b1) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin
      errors++; $display("[TB] FAIL abort_valid got %0d pulses want 0", seen);
    end
    checks++; if (yk_a !== '0 || busy_a !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_state yk=%h busy=%b want 0/0", yk_a, busy_a);
    end
    applyStimulus(0, 100, 100, 0, 0, 0, lat, bc, vc);
    checks++; if (act_yk(0, 0) !== -28 || act_yk(0, 1) !== -28) begin
      errors++; $display("[TB] FAIL reprime_yk got %0d,%0d want -28", act_yk(0, 0), act_yk(0, 1));
    end
  endtask

  task automatic test_random();
    int lat, bc, vc, inst;
    int p [4];
    for (int it = 0; it < 18; it++) begin
      inst = it % 3;
      for (int i = 0; i < 4; i++) p[i] = $urandom_range(0, 255);
      applyStimulus(inst, p[0], p[1], p[2], p[3], 0, lat, bc, vc);
      checks++; if (lat != nch(inst) + 1 || vc != 1) begin
        errors++; $display("[TB] FAIL rand_timing it%0d lat=%0d valid=%0d", it, lat, vc);
      end
      for (int c = 0; c < nch(inst); c++) begin
        checks++; if (act_yk(inst, c) !== exp_y[c] || act_sat(inst, c) !== exp_s[c]) begin
          errors++; $display("[TB] FAIL rand_yk it%0d inst%0d ch%0d got %0d/%b want %0d/%b",
                             it, inst, c, act_yk(inst, c), act_sat(inst, c), exp_y[c], exp_s[c]);
        end
      end
    end
  endtask

  initial begin
    $display("[TB] starting yk_avg_compute bench");
    test_reset();
    test_first_pass();
    test_moving_avg();
    test_extremes();
    test_ignore_compute();
    test_wide();
    test_reset_mid_pass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
